simon_round_checker: RTL and testbench

// - Consumer of the 100-entry game_sequence from the sequence generator: plays the first
//   `level` colours on the LEDs, then checks player button presses against them.
// - Correct round -> level+1 and replay; wrong press -> LOSE; level SEQ_LEN cleared -> WIN.
// - Sits between sequence generator, board buttons and LED/score display logic.

---
 rtl/simon_pkg.sv | 21 ++
 rtl/simon_press_detect.sv | 36 +++
 rtl/simon_round_checker.sv | 163 ++++++++++++++++
 tb/tb_simon_round_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared colour/state types and colour decoding for the Simon round checker
package simon_pkg;

    // Colour encoding: 0 red, 1 green, 2 blue, 3 yellow.
    typedef logic [1:0] color_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_WAIT_IN,
        S_NEXT,
        S_WIN,
        S_LOSE
    } state_t;

    function automatic logic [3:0] color_to_onehot(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/simon_press_detect.sv
// rtl/simon_press_detect.sv - rising-edge press detector for the four player buttons
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       while high, detected edges are discarded (previous-value register still tracks btn,
//               so a button held across the end of clear is never seen as a press)
//   btn         synchronised level-high buttons
//   press       one-cycle pulse when any button rises
//   press_mask  one-hot (or multi-hot) of the buttons that rose this cycle
module press_detect
    import simon_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [3:0] btn,
    output logic       press,
    output logic [3:0] press_mask
);

    logic [3:0] btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 4'b0000;
        end else begin
            btn_q <= btn;
        end
    end

    always_comb begin
        press_mask = clear ? 4'b0000 : (btn & ~btn_q);
        press      = |press_mask;
    end

endmodule

// File: rtl/simon_round_checker.sv
// rtl/simon_round_checker.sv - Simon game round engine: plays back the sequence, checks presses
//
// Optional feature: define SIMON_TIMEOUT_EN to lose after TIMEOUT_CYC idle cycles in WAIT_IN.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pulse, honoured only in IDLE/WIN/LOSE
//   game_sequence  colour per step, held stable by the sequence generator
//   btn            synchronised player buttons, one per colour
//   led            one-hot colour display (0 = dark)
//   level          current round length
//   busy           high in every state except IDLE/WIN/LOSE
//   win, lose      high while in WIN / LOSE
module simon_round_checker
    import simon_pkg::*;
#(
    parameter int SEQ_LEN     = 100,
    parameter int ON_CYCLES   = 25000000,
    parameter int OFF_CYCLES  = 12500000,
    parameter int TIMEOUT_CYC = 250000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  color_t                     game_sequence [SEQ_LEN],
    input  logic [3:0]                 btn,
    output logic [3:0]                 led,
    output logic [$clog2(SEQ_LEN+1)-1:0] level,
    output logic                       busy,
    output logic                       win,
    output logic                       lose
);

    localparam int LW   = $clog2(SEQ_LEN + 1);
    localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, state_n;
    logic [LW-1:0] level_n;
    logic [LW-1:0] idx, idx_n;
    logic [TW-1:0] timer, timer_n;
    color_t        cur_color;
    logic          press;
    logic [3:0]    press_mask;

`ifdef SIMON_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0] to_cnt, to_cnt_n;
`endif

    // Edges are only meaningful while waiting for input; anything else is discarded.
    press_detect u_press_detect (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state != S_WAIT_IN),
        .btn        (btn),
        .press      (press),
        .press_mask (press_mask)
    );

    always_comb begin
        cur_color = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (idx == LW'(i)) cur_color = game_sequence[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            level <= '0;
            idx   <= '0;
            timer <= '0;
`ifdef SIMON_TIMEOUT_EN
            to_cnt <= '0;
`endif
        end else begin
            state <= state_n;
            level <= level_n;
            idx   <= idx_n;
            timer <= timer_n;
`ifdef SIMON_TIMEOUT_EN
            to_cnt <= to_cnt_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        level_n = level;
        idx_n   = idx;
        timer_n = timer;
`ifdef SIMON_TIMEOUT_EN
        to_cnt_n = '0;
`endif
        case (state)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    level_n = LW'(1);
                    idx_n   = '0;
                    state_n = S_SHOW_ON;
                end
            end
            S_SHOW_ON: begin
                if (timer == TW'(ON_CYCLES - 1)) state_n = S_SHOW_OFF;
                else                             timer_n = timer + TW'(1);
            end
            S_SHOW_OFF: begin
                if (timer == TW'(OFF_CYCLES - 1)) begin
                    if (idx + LW'(1) == level) begin
                        idx_n   = '0;
                        state_n = S_WAIT_IN;
                    end else begin
                        idx_n   = idx + LW'(1);
                        state_n = S_SHOW_ON;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_WAIT_IN: begin
                if (press) begin
                    // A multi-button press can never equal a one-hot colour, but keep it explicit.
                    if (!$onehot(press_mask) || press_mask != color_to_onehot(cur_color)) begin
                        state_n = S_LOSE;
                    end else if (idx + LW'(1) == level) begin
                        state_n = S_NEXT;
                    end else begin
                        idx_n = idx + LW'(1);
                    end
`ifdef SIMON_TIMEOUT_EN
                end else if (to_cnt == TOW'(TIMEOUT_CYC - 1)) begin
                    state_n = S_LOSE;
                end else begin
                    to_cnt_n = to_cnt + TOW'(1);
`endif
                end
            end
            S_NEXT: begin
                if (level == LW'(SEQ_LEN)) begin
                    state_n = S_WIN;
                end else begin
                    level_n = level + LW'(1);
                    idx_n   = '0;
                    state_n = S_SHOW_ON;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Playback timer always starts from zero in a newly entered state.
        if (state_n != state) timer_n = '0;
    end

    always_comb begin
        led  = 4'b0000;
        busy = !(state == S_IDLE || state == S_WIN || state == S_LOSE);
        win  = (state == S_WIN);
        lose = (state == S_LOSE);
        if (state == S_SHOW_ON)      led = color_to_onehot(cur_color);
        else if (state == S_WAIT_IN) led = btn;
    end

endmodule

// File: tb/tb_simon_round_checker.sv
// tb/tb_simon_round_checker.sv - directed self-checking bench for simon_round_checker
module tb_simon_round_checker;
    import simon_pkg::*;

    localparam int SEQ_LEN = 3;
    localparam int ON_C    = 4;
    localparam int OFF_C   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0000;
    color_t     game_sequence [SEQ_LEN];
    logic [3:0] led;
    logic [1:0] level;
    logic       busy, win, lose;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] mask;
        logic       exp_lose;
        int         exp_level;
    } vec_t;

    vec_t vecs [6];

    simon_round_checker #(
        .SEQ_LEN     (SEQ_LEN),
        .ON_CYCLES   (ON_C),
        .OFF_CYCLES  (OFF_C),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .game_sequence (game_sequence),
        .btn           (btn),
        .led           (led),
        .level         (level),
        .busy          (busy),
        .win           (win),
        .lose          (lose)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        btn   = 4'b0000;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Checks the full playback of `lvl` colours; optional noise press on SHOW_ON cycle 1.
    task automatic playback(input int lvl, input logic [3:0] noise);
        for (int k = 0; k < lvl; k++) begin
            for (int c = 0; c < ON_C; c++) begin
                chk($sformatf("led_on_l%0d_k%0d_c%0d", lvl, k, c), led, 1 << game_sequence[k]);
                chk("level_play", level, lvl);
                if (c == 1) btn = noise;
                if (c == 2) btn = 4'b0000;
                step();
            end
            for (int c = 0; c < OFF_C; c++) begin
                chk($sformatf("led_off_l%0d_k%0d_c%0d", lvl, k, c), led, 0);
                step();
            end
        end
        chk("busy_wait_in", busy, 1);
        chk("led_wait_in", led, 0);
    endtask

    task automatic play_round(input int lvl);
        for (int k = 0; k < lvl; k++) begin
            btn = 4'(1 << game_sequence[k]);
            step();
            btn = 4'b0000;
            step();
        end
    endtask

    initial begin
        game_sequence[0] = 2'd2;
        game_sequence[1] = 2'd0;
        game_sequence[2] = 2'd3;

        vecs[0] = '{4'b0100, 1'b0, 2};
        vecs[1] = '{4'b0001, 1'b1, 1};
        vecs[2] = '{4'b0010, 1'b1, 1};
        vecs[3] = '{4'b1000, 1'b1, 1};
        vecs[4] = '{4'b0101, 1'b1, 1};
        vecs[5] = '{4'b1100, 1'b1, 1};

        // Reset state
        do_reset();
        chk("rst_led", led, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_win", win, 0);
        chk("rst_lose", lose, 0);

        // Reset in the middle of SHOW_ON
        do_start();
        step();
        step();
        chk("mid_show_led", led, 4'b0100);
        rst_n = 1'b0;
        #2;
        chk("async_rst_led", led, 0);
        chk("async_rst_level", level, 0);
        chk("async_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_level", level, 0);

        // Table: single press at level 1
        foreach (vecs[i]) begin
            do_reset();
            do_start();
            playback(1, 4'b0000);
            btn = vecs[i].mask;
            step();
            btn = 4'b0000;
            step();
            chk($sformatf("tbl%0d_lose", i), lose, vecs[i].exp_lose);
            chk($sformatf("tbl%0d_level", i), level, vecs[i].exp_level);
            chk($sformatf("tbl%0d_busy", i), busy, !vecs[i].exp_lose);
        end

        // Full correct game to WIN, with noise during playback and start while busy
        do_reset();
        do_start();
        playback(1, 4'b0010);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy_ignored_level", level, 1);
        chk("start_busy_ignored_busy", busy, 1);
        play_round(1);
        chk("lvl2_level", level, 2);
        playback(2, 4'b1000);
        play_round(2);
        chk("lvl3_level", level, 3);
        playback(3, 4'b0001);
        play_round(3);
        chk("win_win", win, 1);
        chk("win_busy", busy, 0);
        chk("win_level", level, 3);
        chk("win_led", led, 0);
        step();
        chk("win_hold", win, 1);
        do_start();
        chk("restart_level", level, 1);
        chk("restart_win", win, 0);
        chk("restart_led", led, 4'b0100);

        // Wrong colour at level 2
        do_reset();
        do_start();
        playback(1, 4'b0000);
        play_round(1);
        playback(2, 4'b0000);
        play_round(1);
        btn = 4'b0010;
        step();
        btn = 4'b0000;
        chk("l2_wrong_lose", lose, 1);
        chk("l2_wrong_level", level, 2);
        chk("l2_wrong_busy", busy, 0);

        // Button held across WAIT_IN entry is not a press
        do_reset();
        do_start();
        for (int c = 0; c < ON_C; c++) step();
        btn = 4'b0100;
        step();
        step();
        chk("held_led_mirror", led, 4'b0100);
        step();
        step();
        chk("held_no_press_level", level, 1);
        chk("held_no_press_lose", lose, 0);
        btn = 4'b0000;
        step();
        play_round(1);
        chk("held_then_press_level", level, 2);

        // Timeout behaviour
        do_reset();
        do_start();
        playback(1, 4'b0000);
`ifdef SIMON_TIMEOUT_EN
        for (int c = 0; c < 19; c++) step();
        chk("to_not_yet", lose, 0);
        step();
        chk("to_lose", lose, 1);
        chk("to_level", level, 1);
`else
        for (int c = 0; c < 1000; c++) step();
        chk("no_to_busy", busy, 1);
        chk("no_to_lose", lose, 0);
        play_round(1);
        chk("no_to_press_level", level, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
